// File: rtl/cla_seq_div_pkg.sv
`default_nettype none
// ============================================================================
// Module   : div_pkg
// Brief    : Shared types and helpers for the cla_seq_div iterative divider.
// Revision : 1.0  initial release
// ============================================================================
package div_pkg;

    // Default operand/result width of the divider
    localparam int DEF_WIDTH = 4;

    // Divider control states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Step counter must hold the value WIDTH itself
    function automatic int count_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cla_seq_div_if.sv
`default_nettype none
// ============================================================================
// Module   : cla_seq_div_if
// Brief    : start/done handshake bundle between a requester and cla_seq_div.
//            The div_zero flag exists only when DIV_ZERO_DETECT_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
interface cla_seq_div_if
    import div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
`ifdef DIV_ZERO_DETECT_EN
    logic             div_zero;

    modport master (output start, dividend, divisor,
                    input  busy, done, quotient, remainder, div_zero);
    modport slave  (input  start, dividend, divisor,
                    output busy, done, quotient, remainder, div_zero);
`else
    modport master (output start, dividend, divisor,
                    input  busy, done, quotient, remainder);
    modport slave  (input  start, dividend, divisor,
                    output busy, done, quotient, remainder);
`endif
endinterface
`default_nettype wire

// File: rtl/cla_seq_div_cla_sub.sv
`default_nettype none
// ============================================================================
// Module   : cla_sub
// Brief    : N-bit carry-lookahead subtractor, diff = a - b.
//            Built as a + ~b + 1 from generate/propagate terms; every carry is
//            a flat sum-of-products of G/P and the carry-in, no ripple chain.
//            borrow = 1 when a < b (carry-out of the addition is 0).
// Revision : 1.0  initial release
// ============================================================================
module cla_sub #(
    parameter int N = 5
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] diff,
    output logic         borrow
);
    logic [N-1:0] b_inv;
    logic [N-1:0] gen;
    logic [N-1:0] prop;
    logic [N:0]   carry;

    assign b_inv = ~b;
    assign gen   = a & b_inv;
    assign prop  = a ^ b_inv;

    // Lookahead carries: c[i+1] = OR_j (g[j] & p[j+1..i]) | (cin & p[0..i]), cin = 1
    always_comb begin
        logic term;
        logic sum_terms;
        carry    = '0;
        carry[0] = 1'b1;
        for (int i = 0; i < N; i++) begin
            term = 1'b1;
            for (int k = 0; k <= i; k++) begin
                term = term & prop[k];
            end
            sum_terms = term;
            for (int j = 0; j <= i; j++) begin
                term = gen[j];
                for (int k = j + 1; k <= i; k++) begin
                    term = term & prop[k];
                end
                sum_terms = sum_terms | term;
            end
            carry[i+1] = sum_terms;
        end
    end

    assign diff   = prop ^ carry[N-1:0];
    assign borrow = ~carry[N];

endmodule
`default_nettype wire

// File: rtl/cla_seq_div.sv
`default_nettype none
// ============================================================================
// Module   : cla_seq_div
// Brief    : Iterative unsigned restoring divider, one quotient bit per clock,
//            each trial subtraction done in a WIDTH+1-bit lookahead subtractor.
//            Optional macro DIV_ZERO_DETECT_EN: a zero divisor skips iteration
//            and reports div_zero with a single-cycle latency.
// Revision : 1.0  initial release
// ============================================================================
module cla_seq_div
    import div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic          clk,
    input  logic          rst_n,
    cla_seq_div_if.slave  bus
);
    localparam int CNT_W = count_width(WIDTH);

    state_t             state;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   dvs;
    logic [CNT_W-1:0]   count;
    logic               busy_reg;
    logic               done_reg;
    logic [WIDTH-1:0]   quotient_reg;
    logic [WIDTH-1:0]   remainder_reg;
`ifdef DIV_ZERO_DETECT_EN
    logic               div_zero_reg;
`endif

    // Partial remainder after shifting in the next dividend bit; needs WIDTH+1
    // bits because rem < divisor can still double past 2**WIDTH.
    logic [WIDTH:0]     rem_shift;
    logic [WIDTH:0]     sub_diff;
    logic               sub_borrow;
    logic               unused_diff_msb;
    logic [WIDTH-1:0]   rem_next;
    logic [WIDTH-1:0]   quo_next;
    logic               accept;

    assign rem_shift = {rem, quo[WIDTH-1]};

    cla_sub #(.N(WIDTH + 1)) u_sub (
        .a      (rem_shift),
        .b      ({1'b0, dvs}),
        .diff   (sub_diff),
        .borrow (sub_borrow)
    );

    // A successful trial always leaves a difference below the divisor, so the
    // top difference bit is never needed.
    assign unused_diff_msb = sub_diff[WIDTH];
    assign rem_next        = sub_borrow ? rem_shift[WIDTH-1:0] : sub_diff[WIDTH-1:0];
    assign quo_next        = {quo[WIDTH-2:0], ~sub_borrow};
    assign accept          = bus.start && ((state == IDLE) || (state == DONE));

    // Control FSM, iteration datapath and registered result outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            quo           <= '0;
            rem           <= '0;
            dvs           <= '0;
            count         <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
`ifdef DIV_ZERO_DETECT_EN
            div_zero_reg  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        quo      <= bus.dividend;
                        dvs      <= bus.divisor;
                        rem      <= '0;
                        count    <= CNT_W'(WIDTH);
                        done_reg <= 1'b0;
                        busy_reg <= 1'b1;
                        state    <= RUN;
`ifdef DIV_ZERO_DETECT_EN
                        div_zero_reg <= 1'b0;
                        if (bus.divisor == '0) begin
                            busy_reg      <= 1'b0;
                            done_reg      <= 1'b1;
                            div_zero_reg  <= 1'b1;
                            quotient_reg  <= '1;
                            remainder_reg <= bus.dividend;
                            state         <= DONE;
                        end
`endif
                    end else begin
                        done_reg <= 1'b0;
                        state    <= IDLE;
                    end
                end
                RUN: begin
                    quo   <= quo_next;
                    rem   <= rem_next;
                    count <= count - CNT_W'(1);
                    if (count == CNT_W'(1)) begin
                        busy_reg      <= 1'b0;
                        done_reg      <= 1'b1;
                        quotient_reg  <= quo_next;
                        remainder_reg <= rem_next;
                        state         <= DONE;
                    end
                end
                default: begin
                    busy_reg <= 1'b0;
                    done_reg <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy      = busy_reg;
    assign bus.done      = done_reg;
    assign bus.quotient  = quotient_reg;
    assign bus.remainder = remainder_reg;
`ifdef DIV_ZERO_DETECT_EN
    assign bus.div_zero  = div_zero_reg;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cla_seq_div.sv
`default_nettype none
// ============================================================================
// Module   : tb_cla_seq_div
// Brief    : Self-checking bench for cla_seq_div (WIDTH=4), directed cases,
//            random operands and a full operand sweep against / and %.
//            Honours DIV_ZERO_DETECT_EN when defined.
// Revision : 1.0  initial release
// ============================================================================
module tb_cla_seq_div;
    localparam int W = 4;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;
    logic [W-1:0] last_q;
    logic [W-1:0] last_r;

    cla_seq_div_if #(.WIDTH(W)) bus ();

    cla_seq_div #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic accept_op(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // Waits for done after an accepted start and checks against plain arithmetic
    task automatic finish_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit noise);
        int n;
        int busy_cnt;
        int exp_lat;
        int eq;
        int er;
        eq = (b == 0) ? (1 << W) - 1 : int'(a) / int'(b);
        er = (b == 0) ? int'(a) : int'(a) % int'(b);
        exp_lat = W;
`ifdef DIV_ZERO_DETECT_EN
        if (b == 0) exp_lat = 0;
`endif
        n = 0;
        busy_cnt = 0;
        while (bus.done !== 1'b1 && n < 20) begin
            if (bus.busy === 1'b1) busy_cnt++;
            chk("hold_quotient", bus.quotient, last_q);
            chk("hold_remainder", bus.remainder, last_r);
            if (noise) begin
                bus.start    = 1'b1;
                bus.dividend = 4'd6;
                bus.divisor  = 4'd2;
            end
            @(posedge clk);
            #1;
            n++;
        end
        bus.start = 1'b0;
        chk("latency", n, exp_lat);
        chk("busy_cycles", busy_cnt, exp_lat);
        chk("busy_at_done", bus.busy, 1'b0);
        chk("quotient", bus.quotient, eq);
        chk("remainder", bus.remainder, er);
`ifdef DIV_ZERO_DETECT_EN
        chk("div_zero", bus.div_zero, (b == 0) ? 1 : 0);
`endif
        last_q = eq[W-1:0];
        last_r = er[W-1:0];
    endtask

    task automatic after_done();
        @(posedge clk);
        #1;
        chk("done_pulse", bus.done, 1'b0);
        chk("result_held_q", bus.quotient, last_q);
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit noise);
        accept_op(a, b);
        finish_op(a, b, noise);
        after_done();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_done"}, bus.done, 0);
        chk({tag, "_quotient"}, bus.quotient, 0);
        chk({tag, "_remainder"}, bus.remainder, 0);
`ifdef DIV_ZERO_DETECT_EN
        chk({tag, "_div_zero"}, bus.div_zero, 0);
`endif
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        vectors      = 0;
        miscompares  = 0;
        last_q       = '0;
        last_r       = '0;
        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Directed operand patterns
        run_op(4'd13, 4'd3, 1'b0);
        run_op(4'd15, 4'd1, 1'b0);
        run_op(4'd2,  4'd9, 1'b0);
        run_op(4'd0,  4'd7, 1'b0);
        run_op(4'd9,  4'd0, 1'b0);

        // start held high during RUN must be ignored
        run_op(4'd13, 4'd3, 1'b1);

        // Back-to-back: new start in the DONE cycle
        accept_op(4'd13, 4'd3);
        finish_op(4'd13, 4'd3, 1'b0);
        bus.start    = 1'b1;
        bus.dividend = 4'd14;
        bus.divisor  = 4'd4;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        chk("b2b_done_drop", bus.done, 0);
        chk("b2b_busy_rise", bus.busy, 1);
        finish_op(4'd14, 4'd4, 1'b0);
        after_done();

        // Asynchronous reset in the middle of RUN
        run_op(4'd11, 4'd2, 1'b0);
        accept_op(4'd13, 4'd3);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("midrun_reset");
        @(negedge clk);
        rst_n  = 1'b1;
        last_q = '0;
        last_r = '0;
        run_op(4'd13, 4'd3, 1'b0);

        // Random operands
        repeat (40) begin
            ra = W'($urandom_range(0, (1 << W) - 1));
            rb = W'($urandom_range(0, (1 << W) - 1));
            run_op(ra, rb, 1'b0);
        end

        // Full operand sweep
        for (int a = 0; a < (1 << W); a++) begin
            for (int b = 0; b < (1 << W); b++) begin
                run_op(W'(a), W'(b), 1'b0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
